// File: rtl/spi_master_arbiter_if.sv
// Requester-side handshake and SPI pin bundle for spi_master_arbiter.
// The master modport is the engine's view; the slave modport is the environment's view.
interface spi_master_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      rx_data;
  logic                  busy;
  logic                  SCLK;
  logic [NREQ-1:0]       CS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  req, req_data, MISO,
    output grant, done, rx_data, busy, SCLK, CS, MOSI
  );

  modport slave (
    output req, req_data, MISO,
    input  grant, done, rx_data, busy, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Shared SPI master: round-robin arbitration over NREQ requesters, each owning one CS line,
// followed by a single LSB-first full-duplex WIDTH-bit exchange clocked by a tick divider.
module spi_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_master_arbiter_if.master  bus
);
  localparam int LW = (NREQ > 1)    ? $clog2(NREQ)    : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;

  // ARB is the cycle between sampling the requests and presenting the grant.
  typedef enum logic [2:0] {IDLE, ARB, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state;
  logic [LW-1:0]     last;
  logic [LW-1:0]     win;
  logic [LW-1:0]     pick;
  logic              found;
  int                idx;
  logic [DW-1:0]     div;
  logic              active;
  logic              tick;
  logic [BW-1:0]     bitcnt;
  logic [WIDTH-1:0]  tx;
  logic [WIDTH-1:0]  rx;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   cs;
  logic [WIDTH-1:0]  rx_data;
  logic              busy;
  logic              sclk;
  logic              mosi;

  assign bus.grant   = grant;
  assign bus.done    = done;
  assign bus.CS      = cs;
  assign bus.rx_data = rx_data;
  assign bus.busy    = busy;
  assign bus.SCLK    = sclk;
  assign bus.MOSI    = mosi;

  // Search starts just after the last winner so a persistent requester cannot starve others.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && bus.req[idx[LW-1:0]]) begin
        found = 1'b1;
        pick  = idx[LW-1:0];
      end
    end
  end

  assign active = (state != IDLE) && (state != ARB);
  assign tick   = active && (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= LW'(NREQ - 1);
      win     <= '0;
      div     <= '0;
      bitcnt  <= '0;
      tx      <= '0;
      rx      <= '0;
      grant   <= '0;
      done    <= '0;
      cs      <= '1;
      rx_data <= '0;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= '0;
      if (active) div <= tick ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            win   <= pick;
            state <= ARB;
          end
        end
        ARB: begin
          grant  <= NREQ'(1) << win;
          cs     <= ~(NREQ'(1) << win);
          busy   <= 1'b1;
          tx     <= bus.req_data[int'(win)*WIDTH +: WIDTH];
          last   <= win;
          div    <= '0;
          bitcnt <= '0;
          state  <= SETUP;
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!sclk) begin
              mosi <= tx[0];
              tx   <= tx >> 1;
            end else begin
              rx     <= {bus.MISO, rx[WIDTH-1:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == BW'(WIDTH - 1)) state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs      <= '1;
            grant   <= '0;
            mosi    <= 1'b0;
            rx_data <= rx;
            done    <= NREQ'(1) << win;
            state   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
